// File: rtl/word_render_engine.sv
// Word render engine: clears a rectangle, draws underscores and a cursor marker,
// then scans revealed glyphs through an external font ROM as a pixel stream.
module word_render_engine #(
  parameter int NUM_LETTERS = 10,
  parameter int GLYPH_W     = 3,
  parameter int GLYPH_H     = 5,
  parameter int PITCH       = 4,
  parameter int ORIGIN_X    = 20,
  parameter int ORIGIN_Y    = 100,
  parameter int CLEAR_W     = 41,
  parameter int CLEAR_H     = 10,
  parameter int COORD_W     = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8*NUM_LETTERS-1:0] letters,
  input  logic [NUM_LETTERS-1:0]   reveal,
  input  logic [3:0]               cursor_idx,
  input  logic [2:0]               letter_col,
  output logic [7:0]               glyph_code,
  output logic [2:0]               glyph_row,
  input  logic [GLYPH_W-1:0]       glyph_bits,
  output logic [COORD_W-1:0]       x,
  output logic [COORD_W-1:0]       y,
  output logic [2:0]               colour,
  output logic                     plot,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W  = $clog2(CLEAR_W + CLEAR_H + GLYPH_W + GLYPH_H);
  localparam int SLOT_W = $clog2(NUM_LETTERS + 1);

  localparam logic [CNT_W-1:0]   CLR_W_LAST = CNT_W'(CLEAR_W - 1);
  localparam logic [CNT_W-1:0]   CLR_H_LAST = CNT_W'(CLEAR_H - 1);
  localparam logic [CNT_W-1:0]   GW_LAST    = CNT_W'(GLYPH_W - 1);
  localparam logic [CNT_W-1:0]   GH_LAST    = CNT_W'(GLYPH_H - 1);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_LETTERS - 1);
  localparam logic [COORD_W-1:0] OX         = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] OY         = COORD_W'(ORIGIN_Y);
  localparam logic [COORD_W-1:0] UNDER_Y    = COORD_W'(ORIGIN_Y + GLYPH_H + 1);
  localparam logic [COORD_W-1:0] CURSOR_Y   = COORD_W'(ORIGIN_Y + GLYPH_H + 3);

  typedef enum logic [2:0] {IDLE, CLEAR, UNDER, CURSOR, LETTERS, DONE} state_t;

  state_t                   state;
  state_t                   next_phase;
  logic [8*NUM_LETTERS-1:0] letters_q;
  logic [NUM_LETTERS-1:0]   reveal_q;
  logic [3:0]               cursor_q;
  logic [2:0]               colour_q;
  logic [SLOT_W-1:0]        slot;
  logic [CNT_W-1:0]         cnt_i;
  logic [CNT_W-1:0]         cnt_o;
  logic                     plot_q;
  logic                     letter_bit;
  logic                     adv;
  logic                     last_px;
  logic                     cursor_ok;
  logic                     first_ok;
  logic                     next_ok;
  logic [SLOT_W-1:0]        first_slot;
  logic [SLOT_W-1:0]        next_slot;
  logic [SLOT_W-1:0]        sel_slot;

  function automatic logic [COORD_W-1:0] slot_x(input int s);
    return OX + COORD_W'(s * PITCH);
  endfunction

  // NOTE: during the glyph scan the font answers in the same cycle, so plot is
  // a combinational pick from glyph_bits; every other phase uses the register.
  always_comb begin
    letter_bit = 1'b0;
    for (int c = 0; c < GLYPH_W; c++)
      if (cnt_i == CNT_W'(c)) letter_bit = glyph_bits[GLYPH_W-1-c];
  end

  assign plot      = (state == LETTERS) ? letter_bit : plot_q;
  assign adv       = !plot || pix_ready;
  assign cursor_ok = int'(cursor_q) < NUM_LETTERS;

  // Lowest revealed slot overall, and lowest revealed slot above the current one.
  always_comb begin
    first_ok   = 1'b0;
    first_slot = '0;
    next_ok    = 1'b0;
    next_slot  = '0;
    for (int k = NUM_LETTERS - 1; k >= 0; k--) begin
      if (reveal_q[k]) begin
        first_ok   = 1'b1;
        first_slot = SLOT_W'(k);
        if (k > int'(slot)) begin
          next_ok   = 1'b1;
          next_slot = SLOT_W'(k);
        end
      end
    end
  end

  always_comb begin
    last_px    = 1'b0;
    next_phase = DONE;
    sel_slot   = (state == LETTERS) ? next_slot : first_slot;
    case (state)
      CLEAR: begin
        last_px    = (cnt_i == CLR_H_LAST) && (cnt_o == CLR_W_LAST);
        next_phase = UNDER;
      end
      UNDER: begin
        last_px    = (cnt_i == GW_LAST) && (slot == SLOT_LAST);
        next_phase = cursor_ok ? CURSOR : (first_ok ? LETTERS : DONE);
      end
      CURSOR: begin
        last_px    = (cnt_i == GW_LAST);
        next_phase = first_ok ? LETTERS : DONE;
      end
      LETTERS: begin
        last_px    = (cnt_i == GW_LAST) && (cnt_o == GH_LAST);
        next_phase = next_ok ? LETTERS : DONE;
      end
      default: ;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      letters_q  <= '0;
      reveal_q   <= '0;
      cursor_q   <= '0;
      colour_q   <= '0;
      slot       <= '0;
      cnt_i      <= '0;
      cnt_o      <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot_q     <= 1'b0;
      glyph_code <= '0;
      glyph_row  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (state inside {CLEAR, UNDER, CURSOR, LETTERS} && adv && last_px) begin
      state <= next_phase;
      cnt_i <= '0;
      cnt_o <= '0;
      case (next_phase)
        UNDER: begin
          slot   <= '0;
          x      <= OX;
          y      <= UNDER_Y;
          colour <= 3'b111;
        end
        CURSOR: begin
          x      <= slot_x(int'(cursor_q));
          y      <= CURSOR_Y;
          colour <= 3'b100;
        end
        LETTERS: begin
          slot       <= sel_slot;
          x          <= slot_x(int'(sel_slot));
          y          <= OY;
          colour     <= colour_q;
          glyph_code <= letters_q[int'(sel_slot)*8 +: 8];
          glyph_row  <= '0;
        end
        default: begin
          x          <= '0;
          y          <= '0;
          colour     <= '0;
          plot_q     <= 1'b0;
          glyph_code <= '0;
          glyph_row  <= '0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            letters_q <= letters;
            reveal_q  <= reveal;
            cursor_q  <= cursor_idx;
            colour_q  <= letter_col;
            state     <= CLEAR;
            busy      <= 1'b1;
            plot_q    <= 1'b1;
            colour    <= 3'b000;
            x         <= OX;
            y         <= OY;
            cnt_i     <= '0;
            cnt_o     <= '0;
          end
        end
        CLEAR: begin
          if (adv) begin
            if (cnt_i != CLR_H_LAST) begin
              cnt_i <= cnt_i + 1'b1;
              y     <= y + 1'b1;
            end else begin
              cnt_i <= '0;
              cnt_o <= cnt_o + 1'b1;
              y     <= OY;
              x     <= x + 1'b1;
            end
          end
        end
        UNDER: begin
          if (adv) begin
            if (cnt_i != GW_LAST) begin
              cnt_i <= cnt_i + 1'b1;
              x     <= x + 1'b1;
            end else begin
              cnt_i <= '0;
              slot  <= slot + 1'b1;
              x     <= slot_x(int'(slot) + 1);
            end
          end
        end
        CURSOR: begin
          if (adv) begin
            cnt_i <= cnt_i + 1'b1;
            x     <= x + 1'b1;
          end
        end
        LETTERS: begin
          if (adv) begin
            if (cnt_i != GW_LAST) begin
              cnt_i <= cnt_i + 1'b1;
              x     <= x + 1'b1;
            end else begin
              cnt_i     <= '0;
              cnt_o     <= cnt_o + 1'b1;
              x         <= slot_x(int'(slot));
              y         <= y + 1'b1;
              glyph_row <= glyph_row + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/word_render_engine.md
WORD_RENDER_ENGINE -- requirements
Module: word_render_engine

Interface
REQ-001 Parameter NUM_LETTERS, default 10: number of letter slots.
REQ-002 Parameter GLYPH_W, default 3: glyph width in pixels.
REQ-003 Parameter GLYPH_H, default 5: glyph height in pixels.
REQ-004 Parameter PITCH, default 4: x spacing between slot origins.
REQ-005 Parameter ORIGIN_X, default 20; ORIGIN_Y, default 100: top-left corner of slot 0.
REQ-006 Parameter CLEAR_W, default 41; CLEAR_H, default 10: size of the blanked region starting at the origin.
REQ-007 Parameter COORD_W, default 7: x and y width.
REQ-008 Ports: one clock; reset is asynchronous and active-high (clock, reset).
REQ-009 clock  in  1  rising-edge clock.
REQ-010 reset  in  1  async active-high reset.
REQ-011 start  in  1  single-cycle frame request.
REQ-012 letters  in  8*NUM_LETTERS  letter codes; slot k is bits [8k+7:8k].
REQ-013 reveal  in  NUM_LETTERS  bit k=1 draws slot k's glyph.
REQ-014 cursor_idx  in  4  slot that receives the cursor marker.
REQ-015 letter_col  in  3  colour of glyph pixels.
REQ-016 glyph_code  out  8  code of the slot being scanned.
REQ-017 glyph_row  out  3  glyph row being scanned (0 = top).
REQ-018 glyph_bits  in  GLYPH_W  external font row, same-cycle combinational; MSB = leftmost column.
REQ-019 x, y  out  COORD_W  pixel coordinate.
REQ-020 colour  out  3  pixel colour.
REQ-021 plot  out  1  pixel valid.
REQ-022 pix_ready  in  1  sink accepts the pixel.
REQ-023 busy  out  1  high from start acceptance until done.
REQ-024 done  out  1  one-cycle frame-complete pulse.

Function
REQ-025 FSM states: IDLE, CLEAR, UNDER, CURSOR, LETTERS, DONE; the order of phases is fixed.
REQ-026 IDLE: start=1 latches letters, reveal, cursor_idx and letter_col, then goes to CLEAR; first pixel appears the next cycle.
REQ-027 start while busy is ignored; latched inputs do not change mid-frame.
REQ-028 CLEAR: every pixel of CLEAR_W x CLEAR_H is emitted with plot=1 and colour=000, column-major (y inner), from (ORIGIN_X, ORIGIN_Y).
REQ-029 UNDER: each slot k emits GLYPH_W pixels at x=ORIGIN_X+k*PITCH+i, y=ORIGIN_Y+GLYPH_H+1, colour=111; slots run in ascending order.
REQ-030 CURSOR: if cursor_idx<NUM_LETTERS, emits GLYPH_W pixels at y=ORIGIN_Y+GLYPH_H+3, colour=100, at slot cursor_idx x positions; otherwise the phase takes zero cycles.
REQ-031 LETTERS: for each slot with reveal[k]=1, scans GLYPH_W*GLYPH_H positions, row-major.
REQ-032 During the LETTERS scan: glyph_code=letters[k]; glyph_row=row; plot=glyph_bits[GLYPH_W-1-col]; colour=letter_col.
REQ-033 Slots with reveal[k]=0 take zero cycles.
REQ-034 Handshake: while plot=1 and pix_ready=0, x, y, colour, plot and all counters hold.
REQ-035 A plot=0 cycle never stalls.
REQ-036 After the last pixel is accepted: DONE for one cycle with done=1, then IDLE, with busy=0 from the DONE cycle.
REQ-037 Coordinate arithmetic is modulo 2^COORD_W (wrap, no saturation).
REQ-038 glyph_code and glyph_row are 0 outside LETTERS.
REQ-039 Frame cycle count with no stalls: CLEAR_W*CLEAR_H + NUM_LETTERS*GLYPH_W + (cursor valid ? GLYPH_W : 0) + popcount(reveal)*GLYPH_W*GLYPH_H.

Reset
REQ-040 Reset asserted at any time, including mid-frame, forces IDLE.
REQ-041 Reset forces x=0, y=0, colour=000, plot=0, busy=0, done=0, glyph_code=0, glyph_row=0.
REQ-042 Reset clears all counters and latched inputs.
REQ-043 First start after reset release begins a full frame.

Verification
REQ-044 Defaults, reveal=0, cursor_idx=0, pix_ready=1, start pulse -> 443 plot cycles: 410 black (first (20,100), last (60,109)), 30 white at y=106, 3 red at (20..22,108). done pulses once the following cycle.
REQ-045 reveal=10'b0000000100, glyph_bits=111 -> 15 extra plot pixels, colour=letter_col, x=28..30, y=100..104; glyph_code=letters[23:16].
REQ-046 cursor_idx=12 -> no y=108 pixels; frame is 440 cycles.
REQ-047 pix_ready low for 5 cycles at CLEAR pixel 7 -> pixel 7 is held for 5 cycles, no pixel is skipped or duplicated, and the frame is 5 cycles longer.
REQ-048 Reset asserted at UNDER pixel 10 -> next cycle plot=0, busy=0, x=y=0; a later start yields the full REQ-044 sequence.
REQ-049 Second start pulse at CLEAR pixel 50 with changed letters -> ignored; the frame uses the originally latched values.
